// File: rtl/mouse_ctrl_pkg.sv
// Shared types and constants for the PS/2 mouse register writer.
//   wr_state_t      : Avalon write sequencer states
//   REG_*           : word addresses inside the mouse register slave
//   B0_*            : bit positions inside PS/2 packet byte 0
package mouse_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, WR_X, WR_Y, WR_BTN} wr_state_t;

  localparam logic [3:0] REG_X   = 4'd0;
  localparam logic [3:0] REG_Y   = 4'd1;
  localparam logic [3:0] REG_BTN = 4'd2;

  localparam int B0_L    = 0;
  localparam int B0_R    = 1;
  localparam int B0_M    = 2;
  localparam int B0_SYNC = 3;
  localparam int B0_XS   = 4;
  localparam int B0_YS   = 5;
  localparam int B0_XO   = 6;
  localparam int B0_YO   = 7;

endpackage

// File: rtl/mouse_reg_writer_if.sv
// Avalon-MM write port between the mouse register writer (master) and the
// mouse register slave.
//   AVM_CS/AVM_WRITE/AVM_ADDR/AVM_BYTE_EN/AVM_WRITEDATA : master -> slave
//   AVM_WAITREQUEST                                      : slave -> master
interface mouse_reg_writer_if;
  logic        AVM_CS;
  logic        AVM_WRITE;
  logic [3:0]  AVM_ADDR;
  logic [3:0]  AVM_BYTE_EN;
  logic [31:0] AVM_WRITEDATA;
  logic        AVM_WAITREQUEST;

  modport master (output AVM_CS, AVM_WRITE, AVM_ADDR, AVM_BYTE_EN, AVM_WRITEDATA,
                  input  AVM_WAITREQUEST);
  modport slave  (input  AVM_CS, AVM_WRITE, AVM_ADDR, AVM_BYTE_EN, AVM_WRITEDATA,
                  output AVM_WAITREQUEST);
endinterface

// File: rtl/mouse_reg_writer_ps2_packet_assembler.sv
// Assembles 3-byte PS/2 mouse packets.
//   clk, rst_n            : clock, async active-low reset
//   byte_valid/byte_data  : received byte strobe
//   pkt_valid             : combinational strobe in the cycle byte 2 arrives
//   dx, dy                : 9-bit signed deltas (0 when overflow flagged)
//   buttons               : {M,R,L} from byte 0
//   pkt_err               : one-cycle pulse after a byte 0 with bad sync bit
module ps2_packet_assembler
  import mouse_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              pkt_valid,
  output logic signed [8:0] dx,
  output logic signed [8:0] dy,
  output logic [2:0]        buttons,
  output logic              pkt_err
);

  logic [1:0] idx_q, idx_d;
  logic [2:0] btn_q, btn_d;
  logic       xs_q, xs_d, ys_q, ys_d, xo_q, xo_d, yo_q, yo_d;
  logic [7:0] b1_q, b1_d;
  logic       err_q, err_d;

  always_comb begin
    idx_d = idx_q; btn_d = btn_q; b1_d = b1_q;
    xs_d = xs_q; ys_d = ys_q; xo_d = xo_q; yo_d = yo_q;
    err_d = 1'b0;
    pkt_valid = 1'b0;
    if (byte_valid) begin
      case (idx_q)
        2'd0: begin
          if (byte_data[B0_SYNC]) begin
            idx_d = 2'd1;
            btn_d = {byte_data[B0_M], byte_data[B0_R], byte_data[B0_L]};
            xs_d  = byte_data[B0_XS];
            ys_d  = byte_data[B0_YS];
            xo_d  = byte_data[B0_XO];
            yo_d  = byte_data[B0_YO];
          end else begin
            err_d = 1'b1;
          end
        end
        2'd1: begin
          b1_d  = byte_data;
          idx_d = 2'd2;
        end
        default: begin
          idx_d     = 2'd0;
          pkt_valid = 1'b1;
        end
      endcase
    end
    // Byte 2 is used straight off the bus so the cursor can update on the
    // same edge that consumes it.
    dx      = xo_q ? 9'sd0 : {xs_q, b1_q};
    dy      = yo_q ? 9'sd0 : {ys_q, byte_data};
    buttons = btn_q;
    pkt_err = err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= 2'd0; btn_q <= 3'd0; b1_q <= 8'd0;
      xs_q <= 1'b0; ys_q <= 1'b0; xo_q <= 1'b0; yo_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      idx_q <= idx_d; btn_q <= btn_d; b1_q <= b1_d;
      xs_q <= xs_d; ys_q <= ys_d; xo_q <= xo_d; yo_q <= yo_d;
      err_q <= err_d;
    end
  end

endmodule

// File: rtl/mouse_reg_writer.sv
// PS/2 packets -> clamped absolute cursor -> Avalon-MM writes of X, Y and
// buttons to words 0, 1, 2 of the mouse register slave.
//   CLK, RESET_N          : clock, async active-low reset
//   BYTE_VALID/BYTE_DATA  : PS/2 receiver byte stream
//   avm                   : Avalon-MM master port
//   CURSOR_X/Y, BUTTONS   : current cursor state
//   PKT_ERR               : pulse for a dropped out-of-sync byte
//   BUSY                  : write sequencer not idle
module mouse_reg_writer
  import mouse_ctrl_pkg::*;
#(
  parameter int X_MAX   = 639,
  parameter int Y_MAX   = 479,
  parameter int COORD_W = 16
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               BYTE_VALID,
  input  logic [7:0]         BYTE_DATA,
  mouse_reg_writer_if.master avm,
  output logic [COORD_W-1:0] CURSOR_X,
  output logic [COORD_W-1:0] CURSOR_Y,
  output logic [2:0]         BUTTONS,
  output logic               PKT_ERR,
  output logic               BUSY
);

  localparam int SW = COORD_W + 2;
  localparam logic signed [SW-1:0] X_MAX_S = SW'(X_MAX);
  localparam logic signed [SW-1:0] Y_MAX_S = SW'(Y_MAX);

  logic              pkt_valid;
  logic signed [8:0] pkt_dx, pkt_dy;
  logic [2:0]        pkt_btn;

  ps2_packet_assembler u_asm (
    .clk        (CLK),
    .rst_n      (RESET_N),
    .byte_valid (BYTE_VALID),
    .byte_data  (BYTE_DATA),
    .pkt_valid  (pkt_valid),
    .dx         (pkt_dx),
    .dy         (pkt_dy),
    .buttons    (pkt_btn),
    .pkt_err    (PKT_ERR)
  );

  logic [COORD_W-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [COORD_W-1:0] sh_x_q, sh_x_d, sh_y_q, sh_y_d;
  logic [2:0]         btn_q, btn_d, sh_btn_q, sh_btn_d;
  logic               pending_q, pending_d;
  wr_state_t          state_q, state_d;
  logic               write_q, write_d;
  logic [3:0]         addr_q, addr_d;
  logic [31:0]        data_q, data_d;
  logic signed [SW-1:0] x_sum, y_sum;

  always_comb begin
    cur_x_d = cur_x_q; cur_y_d = cur_y_q; btn_d = btn_q;
    sh_x_d = sh_x_q; sh_y_d = sh_y_q; sh_btn_d = sh_btn_q;
    state_d = state_q; pending_d = pending_q;

    // Widened signed sum so both ends saturate instead of wrapping.
    x_sum = $signed({2'b00, cur_x_q}) + SW'(pkt_dx);
    y_sum = $signed({2'b00, cur_y_q}) - SW'(pkt_dy);
    if (pkt_valid) begin
      if (x_sum[SW-1])          cur_x_d = '0;
      else if (x_sum > X_MAX_S) cur_x_d = COORD_W'(X_MAX);
      else                      cur_x_d = x_sum[COORD_W-1:0];
      if (y_sum[SW-1])          cur_y_d = '0;
      else if (y_sum > Y_MAX_S) cur_y_d = COORD_W'(Y_MAX);
      else                      cur_y_d = y_sum[COORD_W-1:0];
      btn_d = pkt_btn;
    end

    case (state_q)
      IDLE: begin
        if (pending_q) begin
          // Older packet is owed a write: send the pre-update values and
          // leave any packet completing now pending for the next round.
          state_d = WR_X;
          sh_x_d = cur_x_q; sh_y_d = cur_y_q; sh_btn_d = btn_q;
          pending_d = pkt_valid;
        end else if (pkt_valid) begin
          // Nothing owed: start immediately with the fresh values.
          state_d = WR_X;
          sh_x_d = cur_x_d; sh_y_d = cur_y_d; sh_btn_d = btn_d;
        end
      end
      default: begin
        if (pkt_valid) pending_d = 1'b1;
        if (!avm.AVM_WAITREQUEST) begin
          case (state_q)
            WR_X:    state_d = WR_Y;
            WR_Y:    state_d = WR_BTN;
            default: state_d = IDLE;
          endcase
        end
      end
    endcase

    write_d = (state_d != IDLE);
    case (state_d)
      WR_X:    begin addr_d = REG_X;   data_d = 32'(sh_x_d);   end
      WR_Y:    begin addr_d = REG_Y;   data_d = 32'(sh_y_d);   end
      WR_BTN:  begin addr_d = REG_BTN; data_d = 32'(sh_btn_d); end
      default: begin addr_d = 4'd0;    data_d = 32'd0;         end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cur_x_q <= COORD_W'(X_MAX / 2);
      cur_y_q <= COORD_W'(Y_MAX / 2);
      btn_q <= 3'd0;
      sh_x_q <= '0; sh_y_q <= '0; sh_btn_q <= 3'd0;
      pending_q <= 1'b0;
      state_q <= IDLE;
      write_q <= 1'b0; addr_q <= 4'd0; data_q <= 32'd0;
    end else begin
      cur_x_q <= cur_x_d; cur_y_q <= cur_y_d; btn_q <= btn_d;
      sh_x_q <= sh_x_d; sh_y_q <= sh_y_d; sh_btn_q <= sh_btn_d;
      pending_q <= pending_d;
      state_q <= state_d;
      write_q <= write_d; addr_q <= addr_d; data_q <= data_d;
    end
  end

  assign avm.AVM_CS        = write_q;
  assign avm.AVM_WRITE     = write_q;
  assign avm.AVM_ADDR      = addr_q;
  assign avm.AVM_BYTE_EN   = write_q ? 4'hF : 4'h0;
  assign avm.AVM_WRITEDATA = data_q;
  assign CURSOR_X          = cur_x_q;
  assign CURSOR_Y          = cur_y_q;
  assign BUTTONS           = btn_q;
  assign BUSY              = (state_q != IDLE);

endmodule

// File: doc/mouse_reg_writer.md
# mouse_reg_writer

Hardware controller that turns a stream of 3-byte PS/2 mouse packets into an absolute, clamped cursor position and button state. It acts as an Avalon-MM master that sequences writes into the mouse register slave: X to word 0, Y to word 1, buttons to word 2. It sits between the PS/2 receiver's byte output and the mouse register slave's Avalon port, so the cursor reaches the exported conduit without CPU involvement.

## Interface
Parameters:
- X_MAX, 639, maximum X coordinate, inclusive
- Y_MAX, 479, maximum Y coordinate, inclusive
- COORD_W, 16, cursor coordinate width

Ports:
- CLK  in  1  single clock for all logic
- RESET_N  in  1  reset, asynchronous, active-low
- BYTE_VALID  in  1  one-cycle strobe; BYTE_DATA is valid
- BYTE_DATA  in  8  received PS/2 byte
- AVM_CS  out  1  chip select; equals AVM_WRITE
- AVM_WRITE  out  1  write request
- AVM_ADDR  out  4  word address: 0, 1 or 2
- AVM_BYTE_EN  out  4  always 4'hF during a write, otherwise 4'h0
- AVM_WRITEDATA  out  32  write data
- AVM_WAITREQUEST  in  1  slave stall; tie to 0 for a zero-wait slave
- CURSOR_X  out  COORD_W  current X
- CURSOR_Y  out  COORD_W  current Y
- BUTTONS  out  3  {M,R,L}
- PKT_ERR  out  1  one-cycle pulse when a byte is dropped for a bad sync bit
- BUSY  out  1  high while the write FSM is not in IDLE

## Operation
- Packet assembly uses byte index 0..2. Byte 0 is accepted only if bit3=1. Otherwise the byte is dropped, PKT_ERR pulses, and the index stays at 0.
- Byte 0 fields: [0]L, [1]R, [2]M, [4]X sign, [5]Y sign, [6]X overflow, [7]Y overflow. Byte 1 is the X delta. Byte 2 is the Y delta.
- Deltas are 9-bit two's complement: {sign, byte}, range -256..+255. If an axis has its overflow bit set, that axis's delta is forced to 0.
- Position update:
  - X_new = clamp(X + dx, 0, X_MAX)
  - Y_new = clamp(Y − dy, 0, Y_MAX), because PS/2 +Y means up
  - Arithmetic is done in COORD_W+2 signed bits before clamping. There is no wrap-around.
- BUTTONS is updated from byte 0 when the packet completes, not when byte 0 arrives.
- Packet completion sets a `pending` flag.
- Write FSM states: IDLE → WR_X → WR_Y → WR_BTN → IDLE.
  - IDLE & pending → WR_X. On this transition, snapshot {X, Y, BUTTONS} into shadow registers and clear pending.
  - Each WR_* state holds AVM_WRITE=1 and stable ADDR/DATA until a cycle with AVM_WAITREQUEST=0. The transfer completes at that edge, and the FSM advances.
  - Write data: WR_X {16'h0, X}, WR_Y {16'h0, Y}, WR_BTN {29'h0, buttons}. All come from the shadow registers.
- A packet that completes while BUSY updates the cursor and sets pending. Any number of such packets coalesce into exactly one further 3-write sequence carrying the latest values, which starts from IDLE afterwards.
- Simultaneous packet completion and IDLE→WR_X: the snapshot takes the pre-update values, and pending is set again.
- Reset values: CURSOR_X = X_MAX>>1, CURSOR_Y = Y_MAX>>1, BUTTONS = 0, byte index 0, pending 0, FSM IDLE, all AVM outputs 0, PKT_ERR 0, BUSY 0.

## Timing
- Byte 2 strobed in cycle N → CURSOR_X, CURSOR_Y and BUTTONS show the new values in cycle N+1.
- With BUSY=0 and WAITREQUEST=0, AVM_WRITE is high in cycles N+1, N+2 and N+3 (ADDR 0, 1, 2), and BUSY=0 in N+4.
- Each WAITREQUEST=1 cycle stretches the current write by one cycle. ADDR and DATA must not change while stalled.
- PKT_ERR is high for exactly the cycle after the rejected byte.
- RESET_N low asserts all reset values immediately, without waiting for CLK, and aborts any write in flight. Operation resumes on the first CLK edge after release.

## Structure
- Package `mouse_ctrl_pkg` holds:
  - the `wr_state_t` enum {IDLE, WR_X, WR_Y, WR_BTN}
  - register address constants REG_X=0, REG_Y=1, REG_BTN=2
  - PS/2 byte-0 bit-position constants
- Sub-module `ps2_packet_assembler` handles sync checking, byte indexing and delta/overflow decode. It outputs a one-cycle `pkt_valid` with dx, dy and buttons.
- The top level holds the clamp accumulator, the pending flag, the shadow registers and the write FSM.

## Test plan
- Reset, then packet 08,0A,05 with WAITREQUEST=0 → cursor (329,234). Writes in order: addr0=0x149, addr1=0xEA, addr2=0x0 on three consecutive cycles.
- Packet 19,F0,00 from reset → dx=−16, X=303, BUTTONS=3'b001. Addr2 receives 0x1.
- Large positive deltas, repeated until saturation → X holds at 639 and Y holds at 0. Further packets leave the values unchanged.
- Byte 0x00 strobed first → PKT_ERR pulses, no write occurs. The next valid packet is processed normally.
- Hold WAITREQUEST=1 for 3 cycles during WR_Y and send two packets while BUSY → addr1 data stays stable throughout the stall. Exactly one further 3-write sequence follows, carrying the final cursor.
- Assert RESET_N low during WR_X → AVM_WRITE drops with no clock edge, and the cursor returns to (319,239).
